// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// default memory top address and port identifiers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  localparam logic [31:0] MEM_TOP_DEFAULT = 32'h0000_2fff;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_addr_fault.sv
// Range and word-alignment check for one request port; purely combinational
// so the fault verdict is available in the same cycle as the grant.
module addr_fault
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] MEM_TOP = MEM_TOP_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        fault
);

  assign fault = (addr > MEM_TOP) || (addr[1:0] != 2'b00);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of the fetch and load/store ports onto the single-port
// data memory; faulting requests are answered locally and counted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [31:0] MEM_TOP  = MEM_TOP_DEFAULT,
  parameter int          ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [31:0]         r0_addr,
  input  logic                r0_we,
  input  logic [31:0]         r0_wdata,
  output logic                r0_rvalid,
  input  logic                r0_rready,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [31:0]         r1_addr,
  input  logic                r1_we,
  input  logic [31:0]         r1_wdata,
  output logic                r1_rvalid,
  input  logic                r1_rready,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [11:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic [1:0]          dbg_state
);

  // Handshakes: a request transfers on the rising edge where valid & ready;
  // a response transfers where rvalid & rready. A waiting requester must hold
  // its request stable, nothing is buffered here.

  state_t state;
  logic   last_grant;
  logic   lat_port;
  logic   lat_we;
  logic   fault0, fault1;
  logic   pick, pick_fault, any_valid, idle_live;

  addr_fault #(.MEM_TOP(MEM_TOP)) u_fault0 (.addr(r0_addr), .fault(fault0));
  addr_fault #(.MEM_TOP(MEM_TOP)) u_fault1 (.addr(r1_addr), .fault(fault1));

  assign any_valid  = r0_valid | r1_valid;
  // Under contention the port that did not win last time gets the grant.
  assign pick       = (r0_valid & r1_valid) ? ~last_grant : r1_valid;
  assign pick_fault = pick ? fault1 : fault0;
  assign idle_live  = rst_n && (state == ST_IDLE);

  assign r0_ready  = idle_live & r0_valid & (pick == PORT_FETCH);
  assign r1_ready  = idle_live & r1_valid & (pick == PORT_LS);
  assign r0_rvalid = (state == ST_RESP) && (lat_port == PORT_FETCH);
  assign r1_rvalid = (state == ST_RESP) && (lat_port == PORT_LS);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= PORT_LS;
      lat_port   <= PORT_FETCH;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            last_grant <= pick;
            lat_port   <= pick;
            lat_we     <= pick ? r1_we : r0_we;
            rsp_rdata  <= '0;
            rsp_err    <= pick_fault;
            if (pick_fault) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              state <= ST_RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= pick ? r1_we : r0_we;
              mem_addr  <= pick ? r1_addr[13:2] : r0_addr[13:2];
              mem_wdata <= pick ? r1_wdata : r0_wdata;
              state     <= ST_MEM;
            end
          end
        end
        ST_MEM: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= lat_we ? ST_RESP : ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          rsp_rdata <= mem_rdata;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (lat_port ? r1_rready : r0_rready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a transaction-level
// reference model (grant order, latency, response contents, fault count).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int ERRCNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                r0_valid = 1'b0, r1_valid = 1'b0;
  logic                r0_ready, r1_ready;
  logic [31:0]         r0_addr = '0, r1_addr = '0;
  logic                r0_we = 1'b0, r1_we = 1'b0;
  logic [31:0]         r0_wdata = '0, r1_wdata = '0;
  logic                r0_rvalid, r1_rvalid;
  logic                r0_rready = 1'b0, r1_rready = 1'b0;
  logic [31:0]         rsp_rdata;
  logic                rsp_err;
  logic                mem_en, mem_we;
  logic [11:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem_rdata = '0;
  logic [ERRCNT_W-1:0] err_cnt;
  logic [1:0]          dbg_state;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] ref_mem [int];
  int          ref_err  = 0;
  int          ref_last = 1;

  // memory macro emulation
  logic [31:0] tbmem [0:3071];

  mem_port_arbiter #(.MEM_TOP(32'h0000_2fff), .ERRCNT_W(ERRCNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_we(r0_we),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rready(r0_rready),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_we(r1_we),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rready(r1_rready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  // clock / memory
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] a);
    return (a > 32'h0000_2fff) || (a % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int idx;
    idx = int'(a / 4) % 4096;
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  // driver tasks
  task automatic drive(input int p, input logic v, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
    if (p == 0) begin r0_valid = v; r0_addr = a; r0_we = w; r0_wdata = d; end
    else        begin r1_valid = v; r1_addr = a; r1_we = w; r1_wdata = d; end
  endtask

  task automatic set_valid(input int p, input logic v);
    if (p == 0) r0_valid = v; else r1_valid = v;
  endtask

  task automatic rnd_req(output logic [31:0] a, output logic w, output logic [31:0] d);
    case ($urandom_range(0, 3))
      0, 1: a = $urandom_range(0, 3071) * 4;
      2:    a = 32'h0000_3000 + $urandom_range(0, 4095) * 4;
      default: a = $urandom_range(0, 3071) * 4 + $urandom_range(1, 3);
    endcase
    w = 1'($urandom_range(0, 1));
    d = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {25'b0, r0_ready, r1_ready, r0_rvalid, r1_rvalid, mem_en, mem_we, rsp_err}, 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_maddr"}, {20'b0, mem_addr}, 32'h0);
    check({tag, "_mwdata"}, mem_wdata, 32'h0);
    check({tag, "_errcnt"}, {28'b0, err_cnt}, 32'h0);
  endtask

  // Called #1 after the negedge of the cycle where port p's request is
  // expected to be granted; returns at the negedge after the rready handshake.
  task automatic serve(input int p, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input int stall);
    logic        f, got;
    int          lat, exp_lat;
    logic [31:0] exp_rd;
    f       = is_fault(a);
    exp_lat = f ? 1 : (w ? 2 : 3);
    exp_rd  = (f || w) ? 32'h0 : ref_rd(a);
    check("grant_ready", p == 1 ? r1_ready : r0_ready, 1);
    check("other_ready", p == 1 ? r0_ready : r1_ready, 0);
    @(posedge clk);
    ref_last = p;
    if (f) begin
      if (ref_err < 15) ref_err++;
    end else if (w) begin
      ref_mem[int'(a / 4) % 4096] = d;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      if (lat == 0) set_valid(p, 1'b0);
      #1;
      lat++;
      if (lat == 1) begin
        check("mem_en_t1", mem_en, !f);
        if (!f) begin
          check("mem_addr", {20'b0, mem_addr}, (a / 4) % 4096);
          check("mem_we", mem_we, w);
          if (w) check("mem_wdata", mem_wdata, d);
        end
      end else begin
        check("mem_en_once", mem_en, 0);
      end
      got = (p == 1) ? r1_rvalid : r0_rvalid;
    end
    check("latency", lat, exp_lat);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, f);
    check("other_rvalid", p == 1 ? r0_rvalid : r1_rvalid, 0);
    check("resp_ready", {r0_ready, r1_ready}, 0);
    check("err_cnt", {28'b0, err_cnt}, ref_err);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      check("stall_rvalid", p == 1 ? r1_rvalid : r0_rvalid, 1);
      check("stall_rdata", rsp_rdata, exp_rd);
      check("stall_ready", {r0_ready, r1_ready}, 0);
    end
    @(negedge clk);
    if (p == 1) r1_rready = 1'b1; else r0_rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r0_rready = 1'b0;
    r1_rready = 1'b0;
  endtask

  task automatic single(input int p, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input int stall);
    drive(p, 1'b1, a, w, d);
    #1;
    serve(p, a, w, d, stall);
  endtask

  // both ports kept valid; each served port immediately presents a new request
  task automatic contend(input int n, input logic [31:0] a0, input logic [31:0] a1);
    logic [31:0] a [2];
    logic        w [2];
    logic [31:0] d [2];
    int          p;
    a[0] = a0; w[0] = 1'b0; d[0] = 32'h0;
    a[1] = a1; w[1] = 1'b0; d[1] = 32'h0;
    drive(0, 1'b1, a[0], w[0], d[0]);
    drive(1, 1'b1, a[1], w[1], d[1]);
    for (int i = 0; i < n; i++) begin
      #1;
      p = (ref_last == 1) ? 0 : 1;
      check("rr_expect", p, i % 2);
      serve(p, a[p], w[p], d[p], (i == 1) ? 5 : 0);
      rnd_req(a[p], w[p], d[p]);
      drive(p, 1'b1, a[p], w[p], d[p]);
    end
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic        rw;
    int          rp;
    for (int i = 0; i < 3072; i++) tbmem[i] = 32'h0;
    tbmem[12'h401] = 32'hDEAD_BEEF;
    ref_mem[32'h401] = 32'hDEAD_BEEF;

    // reset defaults, with a request already waiting
    r0_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", {30'b0, dbg_state}, ST_IDLE);
    @(negedge clk);
    r0_valid = 1'b0;
    rst_n = 1'b1;

    // first contention: port 0, then port 1
    @(negedge clk);
    contend(2, 32'h0000_0010, 32'h0000_0020);

    // legal read on port 1
    single(1, 32'h0000_1004, 1'b0, 32'h0, 0);
    // legal write on port 0 at the top word, then read it back
    single(0, 32'h0000_2ffc, 1'b1, 32'h1234_5678, 0);
    single(1, 32'h0000_2ffc, 1'b0, 32'h0, 0);

    // faults: first out of range, then misaligned
    single(0, 32'h0000_3000, 1'b0, 32'h0, 0);
    check("err_cnt_1", {28'b0, err_cnt}, 1);
    single(1, 32'h0000_0002, 1'b1, 32'hffff_ffff, 0);
    check("err_cnt_2", {28'b0, err_cnt}, 2);

    // fairness over 6 transactions with a 5-cycle rready stall
    contend(6, 32'h0000_1004, 32'h0000_2ffc);

    // reset during the read-data wait
    drive(1, 1'b1, 32'h0000_1004, 1'b0, 32'h0);
    #1;
    check("mid_ready", r1_ready, 1);
    @(negedge clk); set_valid(1, 1'b0);
    @(negedge clk); #1;
    check("mid_state", {30'b0, dbg_state}, ST_WAIT_RD);
    rst_n = 1'b0;
    r0_valid = 1'b1;
    #1;
    check_all_zero("mid_reset");
    ref_err  = 0;
    ref_last = 1;
    @(negedge clk);
    r0_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("no_rvalid", {r0_rvalid, r1_rvalid}, 0);
    end

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      ra = (i % 2 == 0) ? 32'h0000_3000 + $urandom_range(0, 255) * 4
                        : $urandom_range(0, 3071) * 4 + 1;
      single(i % 2, ra, 1'b0, 32'h0, 0);
    end
    check("err_cnt_sat", {28'b0, err_cnt}, 15);

    // random single-port traffic
    for (int i = 0; i < 30; i++) begin
      rnd_req(ra, rw, rd);
      rp = int'($urandom_range(0, 1));
      single(rp, ra, rw, rd, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates two word-access requesters (instruction fetch on port 0, load/store on port 1) onto the single-port 12 KiB data memory. Each request is range- and alignment-checked before it reaches memory: legal requests run one memory cycle, faulting requests are answered with an error and never touch memory. The block sits between the core's memory stages and the memory macro, and counts faults for debug readout.

## Interface
- `MEM_TOP`, default `32'h0000_2fff`: highest legal byte address; any higher address faults.
- `ERRCNT_W`, default 16: width of the saturating fault counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `r0_valid`, `r1_valid` in 1: request valid, per port.
- `r0_ready`, `r1_ready` out 1: request accepted when valid&ready.
- `r0_addr`, `r1_addr` in 32: byte address.
- `r0_we`, `r1_we` in 1: 1 = word write, 0 = word read.
- `r0_wdata`, `r1_wdata` in 32: write data.
- `r0_rvalid`, `r1_rvalid` out 1: response valid, per port.
- `r0_rready`, `r1_rready` in 1: response consumed when rvalid&rready.
- `rsp_rdata` out 32: read data for the current response; 0 for writes and faults.
- `rsp_err` out 1: current response is a fault.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 12: word index, equal to `addr[13:2]`.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en`.
- `err_cnt` out ERRCNT_W: saturating count of faulting requests.

## Operation
- Fault rule: `addr > MEM_TOP` or `addr[1:0] != 2'b00`. A request that meets either condition faults.
- FSM states: IDLE, MEM, WAIT_RD, RESP.
- IDLE
  - `rX_ready` = `rX_valid` & granted.
  - Arbitration is round-robin. With both ports valid, the port not granted last wins. With one port valid, that port wins.
  - On accept: latch port id, addr, we and wdata, and update `last_grant`.
  - Legal request: go to MEM.
  - Faulting request: go to RESP with err=1 and `rsp_rdata`=0, and increment `err_cnt` (saturating at all-ones).
- MEM: drive `mem_en`=1, `mem_we`=latched we, `mem_addr`, and `mem_wdata`. A write goes to RESP. A read goes to WAIT_RD.
- WAIT_RD: capture `mem_rdata` into the response register, then go to RESP.
- RESP
  - Assert `rX_rvalid` for the latched port only.
  - Hold `rsp_rdata` and `rsp_err` stable.
  - On `rX_rready`, return to IDLE.
- `r0_ready` and `r1_ready` are 0 outside IDLE. At most one of them is 1 in any cycle.
- `mem_en` is 1 only in MEM, so there is never a memory access for a faulting request.

## Timing
- Reset values (asynchronous, all outputs):
  - State IDLE.
  - All ready, rvalid, `mem_en` and `mem_we` = 0.
  - `rsp_rdata`, `rsp_err`, `mem_addr`, `mem_wdata`, `err_cnt` = 0.
  - `last_grant` = 1, so port 0 wins the first contention.
- Accept in cycle T:
  - Legal read: `mem_en` at T+1, data captured at T+2, rvalid from T+3.
  - Legal write: `mem_en` at T+1, rvalid from T+2.
  - Fault: rvalid from T+1.
- Back-to-back: the next accept can happen no earlier than the cycle after the rready handshake.
- rvalid stays high until rready. Stalling rready holds the FSM in RESP and blocks both ports.
- A request that is valid but not granted must be held stable by its source. The arbiter does not buffer it.
- Reset asserted mid-transaction aborts it. No response is issued, and a pending write may or may not have completed.

## Structure
- Shared package/header: the FSM state encodings, the `MEM_TOP` default, and the port-id constants PORT_FETCH=0 and PORT_LS=1.
- One combinational sub-module, `addr_fault` (addr in, fault out, parameter `MEM_TOP`), instantiated twice: one per request port, so the fault result is known at grant time.

## Test plan
- Reset defaults: hold `rst_n`=0 and check that all outputs are 0. Release reset, then raise r0 and r1 valid together: port 0 is granted first, and after it completes, port 1 is granted.
- Legal read: r1 read at `0x0000_1004`, memory returns `0xDEADBEEF`. Expect `mem_en` at T+1 with `mem_addr`=`0x401`, rvalid at T+3 with `rsp_rdata`=`0xDEADBEEF` and err=0.
- Legal write: r0 write of `0x12345678` to `0x2ffc`. Expect `mem_we`=1 with `mem_addr`=`0xBFF`, and a response at T+2 with err=0.
- Faults:
  - Address `0x3000`: rvalid at T+1 with err=1, `mem_en` stays 0, `err_cnt` = 1.
  - Address `0x0002` (misaligned): err=1, `err_cnt` = 2.
- Contention fairness: keep both ports valid for 6 transactions. Grants alternate 0,1,0,1,0,1. Holding rready=0 for 5 cycles keeps rvalid and `rsp_rdata` stable and both ready signals low.
- Reset mid-read: drop `rst_n` in WAIT_RD. All outputs return to 0 immediately and no rvalid appears after reset.
- `err_cnt` saturation: with `ERRCNT_W`=4, 20 faults leave `err_cnt` at 15.
